// File: rtl/core_port_arbiter.sv
// Small generic FIFO used for the in-flight result ownership tags.
// Latency: push visible at pop_dat the cycle after the write edge; pop_dat is a combinational read.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       lclock,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_vld,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage array: written on push, no reset needed since count guards reads.
    always_ff @(posedge lclock) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge lclock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];

endmodule

// Round-robin share of the adder core's operand port and result port among NREQ requesters.
// Latency: grant->core_in_ready 1 cycle, rd_fall in LOAD_B->req_ack 1 cycle, wr_fall->rsp_valid 1 cycle.
// Backpressure: no grant while TAGQ_DEPTH results are in flight; core_out_ready drops while a result is held.
module core_port_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 32,
    parameter int TAGQ_DEPTH = 4
) (
    input  logic                 lclock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_opa,
    input  logic [NREQ*DW-1:0]   req_opb,
    output logic [NREQ-1:0]      req_ack,
    output logic [2:0]           core_in_ready,
    input  logic [1:0]           core_in_addr,
    input  logic                 core_read,
    output logic [DW-1:0]        core_data_in,
    output logic [2:0]           core_out_ready,
    input  logic [1:0]           core_out_addr,
    input  logic                 core_write,
    input  logic [DW-1:0]        core_data_out,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy,
    output logic                 err_underflow
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TAGQ_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_LOAD_B = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant_idx;
    logic [DW-1:0]   opa_q;
    logic [DW-1:0]   opb_q;
    logic            rd_q;
    logic            wr_q;
    logic            rsp_full;

    logic            rd_fall;
    logic            wr_fall;
    logic [NREQ-1:0] cand;
    logic            scan_found;
    logic [IW-1:0]   scan_idx;
    logic [DW-1:0]   sel_opa;
    logic [DW-1:0]   sel_opb;
    logic            grant_ok;
    logic [IW-1:0]   rr_next;

    logic            tag_push;
    logic            tag_pop;
    logic [IW-1:0]   tag_head;
    logic [CW-1:0]   tag_count;
    logic            tag_empty;

    // Only bit 0 of the input address matters and every output address is equivalent.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{core_out_addr, core_in_addr[1]};

    assign rd_fall   = rd_q & ~core_read;
    assign wr_fall   = wr_q & ~core_write;
    assign tag_empty = (tag_count == '0);
    assign tag_push  = (state == S_LOAD_B) && rd_fall;
    assign tag_pop   = wr_fall && !tag_empty;
    assign busy      = (state != S_IDLE) || !tag_empty;

    // Operands are latched at grant, so the core sees stable data whatever the requester does afterwards.
    assign core_data_in = core_in_addr[0] ? opb_q : opa_q;

    // Round-robin scan from rr_ptr; a requester being acked this cycle is masked because
    // its valid is still high while it reacts to the ack, and it must not be granted again.
    always_comb begin
        logic [IW:0] pos;
        cand       = req_valid & ~req_ack;
        scan_found = 1'b0;
        scan_idx   = '0;
        pos        = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!scan_found && cand[pos[IW-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = pos[IW-1:0];
            end
        end
    end

    // Operand select for the winning requester, using constant slices only.
    always_comb begin
        sel_opa = '0;
        sel_opb = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (IW'(r) == scan_idx) begin
                sel_opa = req_opa[r*DW +: DW];
                sel_opb = req_opb[r*DW +: DW];
            end
        end
    end

    // Next round-robin start point: one past the requester just served, with wrap.
    always_comb begin
        logic [IW:0] inc;
        inc     = {1'b0, grant_idx} + (IW+1)'(1);
        rr_next = (inc >= (IW+1)'(NREQ)) ? '0 : inc[IW-1:0];
    end

    assign grant_ok = scan_found && (tag_count < CW'(TAGQ_DEPTH));

    // Previous-cycle samples of the core strobes for falling-edge detection.
    always_ff @(posedge lclock or negedge reset) begin
        if (!reset) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= core_read;
            wr_q <= core_write;
        end
    end

    // Input FSM: grant, feed opA then opB, then ack the requester and advance the pointer.
    always_ff @(posedge lclock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            core_in_ready <= 3'b000;
            req_ack       <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        grant_idx     <= scan_idx;
                        opa_q         <= sel_opa;
                        opb_q         <= sel_opb;
                        core_in_ready <= 3'b001;
                        state         <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (rd_fall) begin
                        core_in_ready <= 3'b010;
                        state         <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (rd_fall) begin
                        core_in_ready <= 3'b000;
                        req_ack       <= NREQ'(1) << grant_idx;
                        rr_ptr        <= rr_next;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    core_in_ready <= 3'b000;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    // Ownership tags: pushed when the second operand is consumed, popped when a result lands.
    fifo #(
        .W     (IW),
        .DEPTH (TAGQ_DEPTH)
    ) u_tag_fifo (
        .lclock   (lclock),
        .reset    (reset),
        .push_vld (tag_push),
        .push_dat (grant_idx),
        .pop_vld  (tag_pop),
        .pop_dat  (tag_head),
        .count    (tag_count)
    );

    // Result holding register: capture on wr_fall, route to the tag owner, release on its handshake.
    always_ff @(posedge lclock or negedge reset) begin
        if (!reset) begin
            rsp_full       <= 1'b0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            err_underflow  <= 1'b0;
            core_out_ready <= 3'b000;
        end else begin
            core_out_ready <= {3{~rsp_full}};
            if (rsp_full && |(rsp_valid & rsp_ready)) begin
                rsp_full  <= 1'b0;
                rsp_valid <= '0;
            end
            if (wr_fall) begin
                if (!tag_empty) begin
                    rsp_data  <= core_data_out;
                    rsp_valid <= NREQ'(1) << tag_head;
                    rsp_full  <= 1'b1;
                end else begin
                    err_underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_port_arbiter.sv
// Bench for core_port_arbiter: behavioural adder core, requester drivers and a result scoreboard.
// Latency: checks the grant, ack, result and ready-return timing against fixed cycle counts.
// Backpressure: exercises a held core output path and a stalled rsp_ready.
module tb_core_port_arbiter;
    localparam int NREQ       = 4;
    localparam int DW         = 32;
    localparam int TAGQ_DEPTH = 4;

    logic                lclock = 1'b0;
    logic                reset  = 1'b0;
    wire  [NREQ-1:0]     req_valid;
    wire  [NREQ*DW-1:0]  req_opa;
    wire  [NREQ*DW-1:0]  req_opb;
    logic [NREQ-1:0]     req_ack;
    logic [2:0]          core_in_ready;
    logic [1:0]          core_in_addr  = 2'd0;
    logic                core_read     = 1'b0;
    logic [DW-1:0]       core_data_in;
    logic [2:0]          core_out_ready;
    logic [1:0]          core_out_addr = 2'd0;
    logic                core_write    = 1'b0;
    logic [DW-1:0]       core_data_out = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    wire  [NREQ-1:0]     rsp_ready;
    logic                busy;
    logic                err_underflow;

    // Requester side: valid while issued count is ahead of acked count.
    int            issue_cnt [NREQ];
    int            ack_cnt   [NREQ];
    logic [DW-1:0] opa_v     [NREQ];
    logic [DW-1:0] opb_v     [NREQ];
    logic          rsp_ready_en = 1'b0;
    logic          core_hold    = 1'b0;
    int            force_req    = 0;
    int            force_done   = 0;

    typedef struct {
        int            idx;
        logic [DW-1:0] sum;
    } exp_t;
    exp_t exp_q[$];

    logic [NREQ-1:0] ack_log     [256];
    logic [NREQ-1:0] rsp_vec_log [256];
    logic [DW-1:0]   rsp_dat_log [256];
    int n_ack  = 0;
    int n_rsp  = 0;
    int rd_rsp = 0;
    int n_tot  = 0;
    int n_bad  = 0;

    // Core model state.
    int            ci_st = 0;
    int            co_st = 0;
    logic [DW-1:0] a_val = '0;
    logic [DW-1:0] core_q[$];

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign req_valid[g]         = (issue_cnt[g] != ack_cnt[g]);
        assign req_opa[g*DW +: DW]  = opa_v[g];
        assign req_opb[g*DW +: DW]  = opb_v[g];
    end
    assign rsp_ready = {NREQ{rsp_ready_en}};

    always #5 lclock = ~lclock;

    core_port_arbiter #(
        .NREQ       (NREQ),
        .DW         (DW),
        .TAGQ_DEPTH (TAGQ_DEPTH)
    ) dut (
        .lclock         (lclock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_opa        (req_opa),
        .req_opb        (req_opb),
        .req_ack        (req_ack),
        .core_in_ready  (core_in_ready),
        .core_in_addr   (core_in_addr),
        .core_read      (core_read),
        .core_data_in   (core_data_in),
        .core_out_ready (core_out_ready),
        .core_out_addr  (core_out_addr),
        .core_write     (core_write),
        .core_data_out  (core_data_out),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_ready      (rsp_ready),
        .busy           (busy),
        .err_underflow  (err_underflow)
    );

    // Adder core model: reads opA then opB on its input handshake, writes sums on its output handshake.
    always @(negedge lclock) begin
        if (!reset) begin
            ci_st        = 0;
            co_st        = 0;
            core_read    = 1'b0;
            core_in_addr = 2'd0;
            core_write   = 1'b0;
            core_q.delete();
            force_done   = force_req;
        end else begin
            case (ci_st)
                0: if (core_in_ready[0]) begin core_in_addr = 2'd0; core_read = 1'b1; ci_st = 1; end
                1: begin a_val = core_data_in; core_read = 1'b0; ci_st = 2; end
                2: if (core_in_ready[1]) begin core_in_addr = 2'd1; core_read = 1'b1; ci_st = 3; end
                default: begin core_q.push_back(a_val + core_data_in); core_read = 1'b0; ci_st = 0; end
            endcase
            case (co_st)
                0: begin
                    if (force_done != force_req) begin
                        core_data_out = 32'hDEAD_BEEF;
                        core_write    = 1'b1;
                        force_done    = force_done + 1;
                        co_st         = 1;
                    end else if (!core_hold && core_out_ready[0] && core_q.size() > 0) begin
                        core_data_out = core_q.pop_front();
                        core_write    = 1'b1;
                        co_st         = 1;
                    end
                end
                1: begin core_write = 1'b0; co_st = 2; end
                default: co_st = 0;
            endcase
        end
    end

    // Monitor: logs acks (and retires the requester) and every accepted result.
    always @(negedge lclock) begin
        if (req_ack != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) ack_cnt[i] = ack_cnt[i] + 1;
            end
            if (n_ack < 256) ack_log[n_ack] = req_ack;
            n_ack = n_ack + 1;
        end
        if ((rsp_valid & rsp_ready) != '0) begin
            if (n_rsp < 256) begin
                rsp_vec_log[n_rsp] = rsp_valid;
                rsp_dat_log[n_rsp] = rsp_data;
            end
            n_rsp = n_rsp + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tot = n_tot + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge lclock);
        #2;
    endtask

    task automatic send(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        opa_v[r] = a;
        opb_v[r] = b;
        e.idx    = r;
        e.sum    = a + b;
        exp_q.push_back(e);
        issue_cnt[r] = issue_cnt[r] + 1;
    endtask

    task automatic wait_ack(input int target);
        int cyc;
        cyc = 0;
        while (n_ack < target && cyc < 500) begin step(); cyc++; end
        if (n_ack < target) check("ack_timeout", 64'(n_ack), 64'(target));
    endtask

    task automatic drain();
        int target, cyc, idx, found;
        logic [NREQ-1:0] vec;
        target = rd_rsp + exp_q.size();
        cyc    = 0;
        while (n_rsp < target && cyc < 3000) begin step(); cyc++; end
        if (n_rsp < target) check("drain_timeout", 64'(n_rsp), 64'(target));
        while (rd_rsp < n_rsp) begin
            vec = rsp_vec_log[rd_rsp];
            check("rsp_onehot", 64'($onehot(vec)), 64'd1);
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (vec[i]) idx = i;
            found = -1;
            for (int j = 0; j < exp_q.size(); j++) begin
                if (found < 0 && exp_q[j].idx == idx) found = j;
            end
            if (found < 0) begin
                check("rsp_unexpected", 64'(vec), 64'd0);
            end else begin
                check("rsp_data", 64'(rsp_dat_log[rd_rsp]), 64'(exp_q[found].sum));
                exp_q.delete(found);
            end
            rd_rsp++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},      64'(req_ack),        64'd0);
        check({tag, "_in_rdy"},   64'(core_in_ready),  64'd0);
        check({tag, "_out_rdy"},  64'(core_out_ready), 64'd0);
        check({tag, "_data_in"},  64'(core_data_in),   64'd0);
        check({tag, "_rsp_vld"},  64'(rsp_valid),      64'd0);
        check({tag, "_rsp_dat"},  64'(rsp_data),       64'd0);
        check({tag, "_busy"},     64'(busy),           64'd0);
        check({tag, "_err"},      64'(err_underflow),  64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, exp_ptr, cyc, n_before;
        logic [NREQ-1:0] want;

        for (int i = 0; i < NREQ; i++) begin
            issue_cnt[i] = 0;
            ack_cnt[i]   = 0;
            opa_v[i]     = '0;
            opb_v[i]     = '0;
        end
        repeat (3) step();
        check_reset_outputs("rst");

        // Release; core_out_ready must rise on the first edge afterwards.
        reset = 1'b1;
        check("out_rdy_pre", 64'(core_out_ready), 64'd0);
        step();
        check("out_rdy_rel", 64'(core_out_ready), 64'd7);

        // Single pair from requester 2.
        rsp_ready_en = 1'b1;
        send(2, 32'h0000_0005, 32'h0000_0007);
        check("grant_lat0", 64'(core_in_ready), 64'd0);
        step();
        check("grant_lat1", 64'(core_in_ready), 64'd1);
        check("busy_load", 64'(busy), 64'd1);
        wait_ack(1);
        check("single_ack", 64'(ack_log[0]), 64'b0100);
        drain();
        check("single_vec", 64'(rsp_vec_log[0]), 64'b0100);
        check("single_dat", 64'(rsp_dat_log[0]), 64'h0000_000C);
        repeat (5) step();
        check("single_nack", 64'(n_ack), 64'd1);
        check("single_idle", 64'(busy), 64'd0);

        // Fairness: all requesters valid, two rounds, starting one past requester 2.
        exp_ptr = (2 + 1) % NREQ;
        base    = n_ack;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < NREQ; i++) send(i, $urandom, $urandom);
            wait_ack(base + NREQ);
            for (int k = 0; k < NREQ; k++) begin
                want = '0;
                want[(exp_ptr + k) % NREQ] = 1'b1;
                check("rr_order", 64'(ack_log[base + k]), 64'(want));
            end
            base = base + NREQ;
        end
        drain();

        // Backpressure: core output held, so tags fill and the fifth pair must wait.
        rsp_ready_en = 1'b0;
        core_hold    = 1'b1;
        base         = n_ack;
        for (int i = 0; i < NREQ; i++) send(i, $urandom, $urandom);
        wait_ack(base + TAGQ_DEPTH);
        send(1, $urandom, $urandom);
        repeat (20) step();
        check("bp_no_grant", 64'(core_in_ready), 64'd0);
        check("bp_nack", 64'(n_ack), 64'(base + TAGQ_DEPTH));
        check("bp_busy", 64'(busy), 64'd1);
        core_hold = 1'b0;
        wait_ack(base + TAGQ_DEPTH + 1);
        check("bp_fifth", 64'(ack_log[base + TAGQ_DEPTH]), 64'b0010);
        cyc = 0;
        while (rsp_valid == '0 && cyc < 200) begin step(); cyc++; end
        check("bp_held_rdy", 64'(core_out_ready), 64'd0);
        rsp_ready_en = 1'b1;
        step();
        check("bp_clr_vld", 64'(rsp_valid), 64'd0);
        check("bp_clr_rdy", 64'(core_out_ready), 64'd0);
        step();
        check("bp_rdy_back", 64'(core_out_ready), 64'd7);
        drain();

        // Wrap-around sum routed to requester 1 only.
        base = n_ack;
        send(1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_ack(base + 1);
        drain();
        check("wrap_vec", 64'(rsp_vec_log[rd_rsp - 1]), 64'b0010);
        check("wrap_dat", 64'(rsp_dat_log[rd_rsp - 1]), 64'h0000_0001);

        // Underflow: a core write with nothing outstanding.
        repeat (4) step();
        check("uf_pre", 64'(err_underflow), 64'd0);
        n_before  = n_rsp;
        force_req = force_req + 1;
        repeat (6) step();
        check("uf_set", 64'(err_underflow), 64'd1);
        check("uf_no_vld", 64'(rsp_valid), 64'd0);
        check("uf_no_rsp", 64'(n_rsp), 64'(n_before));
        base = n_ack;
        send(0, 32'd100, 32'd23);
        wait_ack(base + 1);
        drain();
        check("uf_sticky", 64'(err_underflow), 64'd1);

        // Reset while the core is reading opB.
        base = n_ack;
        send(3, $urandom, $urandom);
        cyc = 0;
        while (core_in_ready != 3'b010 && cyc < 100) begin step(); cyc++; end
        check("rst_in_loadb", 64'(core_in_ready), 64'd2);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        send(0, $urandom, $urandom);
        repeat (2) step();
        reset = 1'b1;
        wait_ack(base + 2);
        check("post_rst_first", 64'(ack_log[base]), 64'b0001);
        check("post_rst_second", 64'(ack_log[base + 1]), 64'b1000);
        drain();
        check("post_rst_err", 64'(err_underflow), 64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
